// File: rtl/fetch_unit_if.sv
// Instruction-memory read handshake between fetch_unit (master) and the instruction memory (slave).
interface fetch_unit_if;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_rdata_i;

   modport master (output imem_req_o, output imem_addr_o, input imem_ack_i, input imem_rdata_i);
   modport slave  (input imem_req_o, input imem_addr_o, output imem_ack_i, output imem_rdata_i);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem read, holds the fetched word until consumed.
// Optional FETCH_STALL_CNT_EN adds stall-cycle and redirect counters.
//
// state   | meaning
// IDLE    | just out of reset, request starts next cycle
// FETCH   | imem_req_o high, waiting for ack at fetch_pc
// DISCARD | request dropped after a redirect, swallowing the stale ack
// HOLD    | valid_o high, waiting for downstream to consume
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   fetch_unit_if.master imem,
   input  logic        pause_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        valid_o,
   output logic        fetch_stall_o
`ifdef FETCH_STALL_CNT_EN
   ,
   output logic [31:0] stall_cnt_o,
   output logic [15:0] redirect_cnt_o
`endif
);

   typedef enum logic [1:0] {IDLE, FETCH, DISCARD, HOLD} state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic        valid_q, valid_d;
   logic [31:0] target;

   assign target = {redirect_pc_i[31:2], 2'b00};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         pc_q       <= RESET_PC;
         inst_q     <= 32'h0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         pc_q       <= pc_d;
         inst_q     <= inst_d;
         valid_q    <= valid_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      pc_d       = pc_q;
      inst_d     = inst_q;
      valid_d    = valid_q;
      unique case (state_q)
         IDLE: begin
            state_d = FETCH;
            if (redirect_i) fetch_pc_d = target;
         end
         FETCH: begin
            if (imem.imem_ack_i) begin
               if (redirect_i) begin
                  // Redirect wins over the arriving word; a fresh request goes out at the target.
                  fetch_pc_d = target;
               end else begin
                  inst_d     = imem.imem_rdata_i;
                  pc_d       = fetch_pc_q;
                  valid_d    = 1'b1;
                  fetch_pc_d = fetch_pc_q + 32'd4;
                  state_d    = HOLD;
               end
            end else if (redirect_i) begin
               fetch_pc_d = target;
               state_d    = DISCARD;
            end
         end
         DISCARD: begin
            if (redirect_i) fetch_pc_d = target;
            if (imem.imem_ack_i) state_d = FETCH;
         end
         HOLD: begin
            if (redirect_i) begin
               valid_d    = 1'b0;
               fetch_pc_d = target;
               state_d    = FETCH;
            end else if (!pause_i) begin
               valid_d = 1'b0;
               state_d = FETCH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign imem.imem_req_o  = (state_q == FETCH);
   assign imem.imem_addr_o = fetch_pc_q;
   assign pc_o             = pc_q;
   assign inst_o           = inst_q;
   assign valid_o          = valid_q;
   assign fetch_stall_o    = ~valid_q;

`ifdef FETCH_STALL_CNT_EN
   logic [31:0] stall_cnt_q;
   logic [15:0] redirect_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q    <= 32'h0;
         redirect_cnt_q <= 16'h0;
      end else begin
         if (!valid_q && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (redirect_i) redirect_cnt_q <= redirect_cnt_q + 16'd1;
      end
   end

   assign stall_cnt_o    = stall_cnt_q;
   assign redirect_cnt_o = redirect_cnt_q;
`endif

endmodule
